// File: rtl/unpool_pkg.sv
// Shared sizes, FSM encoding and window-position codes for unpool_stream.
// UNPOOL_MASK_EN selects max-unpool; the default build replicates each value.
package unpool_pkg;

    localparam int DATA_W    = 8;
    localparam int OUT_H     = 6;
    localparam int OUT_W     = 6;
    localparam int CH        = 3;
    localparam int POOL_H    = OUT_H / 2;
    localparam int POOL_W    = OUT_W / 2;
    localparam int FRAME_IN  = CH * POOL_H * POOL_W;
    localparam int FRAME_OUT = CH * OUT_H * OUT_W;

    localparam int IN_W    = FRAME_IN * DATA_W;
    localparam int MASK_W  = FRAME_IN * 2;
    localparam int CH_W    = $clog2(CH);
    localparam int ROW_W   = $clog2(OUT_H);
    localparam int COL_W   = $clog2(OUT_W);
    localparam int IDX_W   = $clog2(FRAME_OUT);
    localparam int ELEM_W  = $clog2(FRAME_IN);
    localparam int IN_AW   = $clog2(IN_W);
    localparam int MASK_AW = $clog2(MASK_W);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        UL = 2'd0,
        UR = 2'd1,
        LL = 2'd2,
        LR = 2'd3
    } mask_pos_t;

    // Pooled element that feeds output pixel (ch, row, col).
    function automatic logic [ELEM_W-1:0] elem_index(
        input logic [CH_W-1:0]  ch,
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col
    );
        return ELEM_W'(ch) * ELEM_W'(POOL_H * POOL_W)
             + ELEM_W'(row >> 1) * ELEM_W'(POOL_W)
             + ELEM_W'(col >> 1);
    endfunction

endpackage

// File: rtl/unpool_addr_gen.sv
// Channel/row/column walk over the upsampled frame in flat conv order.
// Produces the flat index and a flag for the final element.
module unpool_addr_gen
    import unpool_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [CH_W-1:0]  ch,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic col_wrap;
    logic row_wrap;

    assign col_wrap = (col == COL_W'(OUT_W - 1));
    assign row_wrap = (row == ROW_W'(OUT_H - 1));
    assign last     = col_wrap && row_wrap && (ch == CH_W'(CH - 1));

    assign idx = IDX_W'(ch) * IDX_W'(OUT_H * OUT_W)
               + IDX_W'(row) * IDX_W'(OUT_W)
               + IDX_W'(col);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ch  <= '0;
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                col <= '0;
                if (row_wrap) begin
                    row <= '0;
                    // Wrapping to 0 leaves the counters ready for the next frame.
                    ch  <= last ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/unpool_stream.sv
// 2x2 unpool: takes one pooled 3x3x3 frame, streams a 6x6x3 frame bytewise.
// Define UNPOOL_MASK_EN for max-unpool (value only at the stored argmax).
module unpool_stream
    import unpool_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   pool_lin,
    input  logic [MASK_W-1:0] pool_mask,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
);

    state_t             state;
    logic [IN_W-1:0]    frame_q;
    logic               accept;
    logic               fire;
    logic               last;
    logic [CH_W-1:0]    ch;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [ELEM_W-1:0]  elem;
    logic [IN_AW-1:0]   bit_base;
    logic [DATA_W-1:0]  value;

    assign accept = in_valid && in_ready;
    assign fire   = out_valid && out_ready;

    unpool_addr_gen u_addr (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .advance (fire),
        .ch      (ch),
        .row     (row),
        .col     (col),
        .idx     (out_idx),
        .last    (last)
    );

    assign elem     = elem_index(ch, row, col);
    assign bit_base = IN_AW'(elem) * IN_AW'(DATA_W);
    assign value    = frame_q[bit_base +: DATA_W];
    assign out_last = last && out_valid;

`ifdef UNPOOL_MASK_EN
    logic [MASK_W-1:0]  mask_q;
    logic [MASK_AW-1:0] mask_base;
    mask_pos_t          pos;
    logic               hit;

    assign mask_base = MASK_AW'(elem) << 1;
    assign pos       = mask_pos_t'({row[0], col[0]});
    assign hit       = (mask_q[mask_base +: 2] == pos);
    assign out_data  = (out_valid && hit) ? value : '0;
`else
    logic unused_mask;

    assign unused_mask = ^pool_mask;
    assign out_data    = out_valid ? value : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        frame_q   <= pool_lin;
`ifdef UNPOOL_MASK_EN
                        mask_q    <= pool_mask;
`endif
                        state     <= STREAM;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                STREAM: begin
                    if (fire && last) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unpool_stream.sv
// Scoreboard bench for unpool_stream: reference model fills a beat queue.
// Build with +define+UNPOOL_MASK_EN to exercise the max-unpool variant.
`timescale 1ns/1ps
module tb_unpool_stream;
    import unpool_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IN_W-1:0]   pool_lin = '0;
    logic [MASK_W-1:0] pool_mask = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    always #5 clk = ~clk;

    unpool_stream dut (
        .clk       (clk),
        .rst       (rst),
        .pool_lin  (pool_lin),
        .pool_mask (pool_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              last;
    } beat_t;

    beat_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic void push_frame(input logic [IN_W-1:0] f,
                                       input logic [MASK_W-1:0] m);
        beat_t b;
        for (int i = 0; i < FRAME_OUT; i++) begin
            int d = i / (OUT_H * OUT_W);
            int r = (i / OUT_W) % OUT_H;
            int c = i % OUT_W;
            int e = d * POOL_H * POOL_W + (r / 2) * POOL_W + c / 2;
            b.data = f[e*DATA_W +: DATA_W];
`ifdef UNPOOL_MASK_EN
            if (int'(m[e*2 +: 2]) != (r % 2) * 2 + (c % 2)) b.data = '0;
`else
            if (m === 'x) b.data = '0;
`endif
            b.idx  = IDX_W'(i);
            b.last = (i == FRAME_OUT - 1);
            sb.push_back(b);
        end
    endfunction

    function automatic logic [IN_W-1:0] count_frame();
        logic [IN_W-1:0] f;
        for (int k = 0; k < FRAME_IN; k++) f[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
        return f;
    endfunction

    function automatic logic [IN_W-1:0] rand_frame();
        logic [IN_W-1:0] f;
        for (int k = 0; k < FRAME_IN; k++) f[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        return f;
    endfunction

    function automatic logic [IN_W-1:0] extreme_frame();
        logic [IN_W-1:0] f;
        for (int k = 0; k < FRAME_IN; k++) f[k*DATA_W +: DATA_W] = (k % 2) ? 8'hFF : 8'h00;
        return f;
    endfunction

    // Called on a falling edge; returns on the edge before the accepting rise.
    task automatic send_frame(input logic [IN_W-1:0] f, input logic [MASK_W-1:0] m);
        int c = 0;
        pool_lin  = f;
        pool_mask = m;
        in_valid  = 1'b1;
        while (!in_ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end else begin
            push_frame(f, m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_last: got %b/%b required 0/0", out_valid, out_last);
        end
        n_tests++;
        if (out_idx !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_idx_data: got %0d/%h required 0/00", out_idx, out_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_replicate();
        int    beats = 0;
        int    cyc = 0;
        beat_t b;
        int    chk_idx[6] = '{0, 1, 6, 2, 36, 107};
        int    chk_val[6] = '{1, 1, 1, 2, 10, 27};
        send_frame(count_frame(), '0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (out_valid !== 1'b1 || out_idx !== '0) begin
            n_fail++;
            $display("FAIL first_latency: valid=%b idx=%0d required 1/0", out_valid, out_idx);
        end
        while (beats < FRAME_OUT && cyc < 1000) begin
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL replicate_extra: idx=%0d with empty queue", out_idx);
                end else begin
                    b = sb.pop_front();
                    if (out_data !== b.data || out_idx !== b.idx || out_last !== b.last) begin
                        n_fail++;
                        $display("FAIL replicate_beat: got %h/%0d/%b required %h/%0d/%b",
                                 out_data, out_idx, out_last, b.data, b.idx, b.last);
                    end
                end
`ifndef UNPOOL_MASK_EN
                for (int j = 0; j < 6; j++) begin
                    if (int'(out_idx) == chk_idx[j]) begin
                        n_tests++;
                        if (out_data !== DATA_W'(chk_val[j])) begin
                            n_fail++;
                            $display("FAIL replicate_fixed idx%0d: got %0d required %0d",
                                     chk_idx[j], out_data, chk_val[j]);
                        end
                    end
                end
`endif
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (beats != FRAME_OUT) begin
            n_fail++;
            $display("FAIL replicate_timeout: got %0d beats required %0d", beats, FRAME_OUT);
        end
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL replicate_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_stall();
        int                beats = 0;
        int                cyc = 0;
        logic              prev_stall = 1'b0;
        logic [DATA_W-1:0] prev_data = '0;
        logic [IDX_W-1:0]  prev_idx = '0;
        beat_t             b;
        send_frame(count_frame(), '0);
        @(negedge clk);
        in_valid = 1'b0;
        while (beats < FRAME_OUT && cyc < 2000) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (prev_stall) begin
                n_tests++;
                if (out_data !== prev_data || out_idx !== prev_idx) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h/%0d required %h/%0d",
                             out_data, out_idx, prev_data, prev_idx);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
            if (out_valid && out_ready && sb.size() > 0) begin
                b = sb.pop_front();
                n_tests++;
                if (out_data !== b.data || out_idx !== b.idx || out_last !== b.last) begin
                    n_fail++;
                    $display("FAIL stall_beat: got %h/%0d/%b required %h/%0d/%b",
                             out_data, out_idx, out_last, b.data, b.idx, b.last);
                end
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (beats != FRAME_OUT || sb.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_count: beats=%0d left=%0d valid=%b required %0d/0/0",
                     beats, sb.size(), out_valid, FRAME_OUT);
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        int              beats = 0;
        int              cyc = 0;
        beat_t           b;
        logic [IN_W-1:0] second = rand_frame();
        out_ready = 1'b1;
        send_frame(count_frame(), '0);
        @(negedge clk);
        pool_lin = second;
        for (int f = 0; f < 2; f++) begin
            beats = 0;
            cyc   = 0;
            while (beats < FRAME_OUT && cyc < 1000) begin
                if (out_valid && out_ready && sb.size() > 0) begin
                    b = sb.pop_front();
                    n_tests++;
                    if (out_data !== b.data || out_idx !== b.idx || out_last !== b.last) begin
                        n_fail++;
                        $display("FAIL b2b_beat f%0d: got %h/%0d/%b required %h/%0d/%b",
                                 f, out_data, out_idx, out_last, b.data, b.idx, b.last);
                    end
                    beats++;
                end
                @(negedge clk);
                cyc++;
            end
            n_tests++;
            if (beats != FRAME_OUT || in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap f%0d: beats=%0d in_ready=%b valid=%b required %0d/1/0",
                         f, beats, in_ready, out_valid, FRAME_OUT);
            end
            if (f == 0) begin
                push_frame(second, '0);
                @(negedge clk);
                in_valid = 1'b0;
                n_tests++;
                if (out_valid !== 1'b1 || out_idx !== '0) begin
                    n_fail++;
                    $display("FAIL b2b_restart: valid=%b idx=%0d required 1/0", out_valid, out_idx);
                end
            end
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int    beats = 0;
        int    cyc = 0;
        beat_t b;
        out_ready = 1'b1;
        send_frame(rand_frame(), '0);
        @(negedge clk);
        in_valid = 1'b0;
        while (beats < 50 && cyc < 500) begin
            if (out_valid) begin
                void'(sb.pop_front());
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== '0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: valid=%b ready=%b idx=%0d last=%b required 0/1/0/0",
                     out_valid, in_ready, out_idx, out_last);
        end
        sb.delete();
        send_frame(extreme_frame(), '0);
        @(negedge clk);
        in_valid = 1'b0;
        beats = 0;
        cyc   = 0;
        while (beats < FRAME_OUT && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready && sb.size() > 0) begin
                b = sb.pop_front();
                n_tests++;
                if (out_data !== b.data || out_idx !== b.idx || out_last !== b.last) begin
                    n_fail++;
                    $display("FAIL extreme_beat: got %h/%0d/%b required %h/%0d/%b",
                             out_data, out_idx, out_last, b.data, b.idx, b.last);
                end
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (beats != FRAME_OUT) begin
            n_fail++;
            $display("FAIL extreme_timeout: got %0d beats required %0d", beats, FRAME_OUT);
        end
        sb.delete();
    endtask

`ifdef UNPOOL_MASK_EN
    task automatic test_mask();
        int              beats = 0;
        int              cyc = 0;
        logic [IN_W-1:0] f;
        logic [DATA_W-1:0] want;
        for (int k = 0; k < FRAME_IN; k++) f[k*DATA_W +: DATA_W] = 8'hAA;
        out_ready = 1'b1;
        send_frame(f, '1);
        @(negedge clk);
        in_valid = 1'b0;
        while (beats < FRAME_OUT && cyc < 1000) begin
            if (out_valid) begin
                want = (((beats / OUT_W) % 2) == 1 && (beats % 2) == 1) ? 8'hAA : 8'h00;
                n_tests++;
                if (out_data !== want || int'(out_idx) != beats) begin
                    n_fail++;
                    $display("FAIL mask_lr: idx=%0d data=%h required idx=%0d data=%h",
                             out_idx, out_data, beats, want);
                end
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (beats != FRAME_OUT) begin
            n_fail++;
            $display("FAIL mask_timeout: got %0d beats required %0d", beats, FRAME_OUT);
        end
        sb.delete();
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_replicate();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef UNPOOL_MASK_EN
        test_mask();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
